// File: rtl/config_operand_packer_pkg.sv
// Shared parameters and helpers for the operand packer and the tree adder it feeds.
// A vector holds one operand per lane, or two half-width operands per lane in halved mode.
package config_operand_packer_pkg;

    localparam int unsigned DEF_P             = 32'd16;
    localparam int unsigned DEF_INPUTS_AMOUNT = 32'd8;

    function automatic int unsigned elems_per_vector(input logic halved,
                                                     input int unsigned inputs_amount);
        if (halved) begin
            return 32'd2 * inputs_amount;
        end else begin
            return inputs_amount;
        end
    endfunction

endpackage

// File: rtl/config_operand_packer_out_reg.sv
// Output stage of the packer: holds one packed vector plus its mode tag.
// Contents stay frozen while valid is high and the consumer is not ready.
module config_packer_out_reg
    import config_operand_packer_pkg::*;
#(
    parameter int unsigned P             = DEF_P,
    parameter int unsigned INPUTS_AMOUNT = DEF_INPUTS_AMOUNT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic signed [P-1:0] load_data [INPUTS_AMOUNT],
    input  logic                load_halved,
    input  logic                ready,
    output logic                valid,
    output logic signed [P-1:0] data [INPUTS_AMOUNT],
    output logic                halved
);

    logic                valid_r;
    logic                halved_r;
    logic signed [P-1:0] data_r [INPUTS_AMOUNT];

    // Vector register: load takes priority; a drained register goes empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r  <= 1'b0;
            halved_r <= 1'b0;
            for (int i = 0; i < INPUTS_AMOUNT; i++) begin
                data_r[i] <= {P{1'b0}};
            end
        end else if (load) begin
            valid_r  <= 1'b1;
            halved_r <= load_halved;
            for (int i = 0; i < INPUTS_AMOUNT; i++) begin
                data_r[i] <= load_data[i];
            end
        end else if (ready) begin
            valid_r <= 1'b0;
        end
    end

    assign valid  = valid_r;
    assign halved = halved_r;
    assign data   = data_r;

endmodule

// File: rtl/config_operand_packer.sv
// Packs a stream of signed operands into lane vectors for the binary tree adder.
// Fill buffer and element counter live here; the finished vector goes to the output stage.
module config_operand_packer
    import config_operand_packer_pkg::*;
#(
    parameter int unsigned P             = DEF_P,
    parameter int unsigned INPUTS_AMOUNT = DEF_INPUTS_AMOUNT
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                halved_precision_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [P-1:0]        in_data_i,
    input  logic                in_last_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic signed [P-1:0] out_data_o [INPUTS_AMOUNT],
    output logic                out_halved_o
);

    localparam int unsigned HALF = P / 32'd2;
    localparam int unsigned CW   = $clog2(32'd2 * INPUTS_AMOUNT);
    localparam int unsigned LW   = $clog2(INPUTS_AMOUNT);
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    logic signed [P-1:0] fill_r      [INPUTS_AMOUNT];
    logic signed [P-1:0] fill_next_s [INPUTS_AMOUNT];
    logic signed [P-1:0] load_data_s [INPUTS_AMOUNT];
    logic [CW-1:0]       cnt_r;
    logic [CW-1:0]       last_idx_s;
    logic [LW-1:0]       lane_idx_s;
    logic                mode_r;
    logic                mode_eff_s;
    logic                pend_r;
    logic                ready_en_r;
    logic                hs_s;
    logic                complete_s;
    logic                out_free_s;
    logic                load_s;
    logic                load_halved_s;

    // A completed vector parked in the fill buffer blocks further input.
    assign in_ready_o = ready_en_r && !pend_r && !clear_i;
    assign hs_s       = in_valid_i && in_ready_o;
    assign out_free_s = !out_valid_o || out_ready_i;

    // Mode, slot addressing and merge of the accepted operand into the fill buffer.
    always_comb begin
        mode_eff_s  = mode_r;
        lane_idx_s  = cnt_r[LW-1:0];
        fill_next_s = fill_r;
        if (cnt_r == CNT_ZERO) begin
            mode_eff_s = halved_precision_i;
        end else begin
            mode_eff_s = mode_r;
        end
        last_idx_s = CW'(elems_per_vector(mode_eff_s, INPUTS_AMOUNT) - 32'd1);
        if (mode_eff_s) begin
            lane_idx_s = cnt_r[CW-1:1];
        end else begin
            lane_idx_s = cnt_r[LW-1:0];
        end
        for (int i = 0; i < INPUTS_AMOUNT; i++) begin
            if (hs_s && (LW'(i) == lane_idx_s)) begin
                if (!mode_eff_s) begin
                    fill_next_s[i] = in_data_i;
                end else if (cnt_r[0]) begin
                    fill_next_s[i] = {fill_r[i][P-1:HALF], in_data_i[HALF-1:0]};
                end else begin
                    fill_next_s[i] = {in_data_i[HALF-1:0], fill_r[i][HALF-1:0]};
                end
            end else begin
                fill_next_s[i] = fill_r[i];
            end
        end
        complete_s = hs_s && (in_last_i || (cnt_r == last_idx_s));
    end

    // Source selection for the output stage: a parked vector drains before new input completes.
    always_comb begin
        load_s        = 1'b0;
        load_data_s   = fill_next_s;
        load_halved_s = mode_eff_s;
        if (clear_i) begin
            load_s = 1'b0;
        end else if (pend_r) begin
            load_s        = out_free_s;
            load_data_s   = fill_r;
            load_halved_s = mode_r;
        end else if (complete_s) begin
            load_s = out_free_s;
        end else begin
            load_s = 1'b0;
        end
    end

    // Fill buffer, element counter, latched mode and parked-vector flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r      <= CNT_ZERO;
            mode_r     <= 1'b0;
            pend_r     <= 1'b0;
            ready_en_r <= 1'b0;
            for (int i = 0; i < INPUTS_AMOUNT; i++) begin
                fill_r[i] <= {P{1'b0}};
            end
        end else begin
            ready_en_r <= 1'b1;
            if (clear_i) begin
                cnt_r  <= CNT_ZERO;
                pend_r <= 1'b0;
                for (int i = 0; i < INPUTS_AMOUNT; i++) begin
                    fill_r[i] <= {P{1'b0}};
                end
            end else if (pend_r) begin
                if (out_free_s) begin
                    pend_r <= 1'b0;
                    for (int i = 0; i < INPUTS_AMOUNT; i++) begin
                        fill_r[i] <= {P{1'b0}};
                    end
                end
            end else if (complete_s) begin
                cnt_r  <= CNT_ZERO;
                mode_r <= mode_eff_s;
                if (out_free_s) begin
                    for (int i = 0; i < INPUTS_AMOUNT; i++) begin
                        fill_r[i] <= {P{1'b0}};
                    end
                end else begin
                    pend_r <= 1'b1;
                    fill_r <= fill_next_s;
                end
            end else if (hs_s) begin
                cnt_r  <= cnt_r + CNT_ONE;
                mode_r <= mode_eff_s;
                fill_r <= fill_next_s;
            end
        end
    end

    config_packer_out_reg #(
        .P             (P),
        .INPUTS_AMOUNT (INPUTS_AMOUNT)
    ) u_out_reg (
        .clk         (clk_i),
        .rst_n       (rst_ni),
        .load        (load_s),
        .load_data   (load_data_s),
        .load_halved (load_halved_s),
        .ready       (out_ready_i),
        .valid       (out_valid_o),
        .data        (out_data_o),
        .halved      (out_halved_o)
    );

endmodule
